pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Owns the program counter and drives the instruction-memory address for the single-cycle processor.
- Each cycle it decodes the control-flow fields of the fetched word and selects the next PC: sequential, branch, jump, jal, jr or bex.
- It exposes the jal link value, redirect and retire counters, and a sticky halt flag raised when the program enters a jump-to-self end loop.
- Sits between skeleton imem and the processor datapath; the PC trace benches observe its address_imem output.

Parameters:
ADDR_WIDTH, 12, PC / imem address width
CNT_WIDTH, 16, width of instr_count and redirect_count (saturating)
HALT_ON_SELF_LOOP, 1, 1 = enter HALT when the next PC equals the current PC on a redirect

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
q_imem  input  32  instruction at address_imem, valid in the same cycle
rd_val  input  32  value of register q_imem[26:22]
rs_val  input  32  value of register q_imem[21:17]
r30_val  input  32  value of $r30 (status register) for bex
stall  input  1  hold PC and counters this cycle
address_imem  output  ADDR_WIDTH  current PC
pc_plus1  output  ADDR_WIDTH  PC+1 modulo 2^ADDR_WIDTH; link value for jal
redirect  output  1  combinational; 1 when next PC is not PC+1 and the cycle is not stalled or halted
instr_count  output  CNT_WIDTH  number of instructions retired
redirect_count  output  CNT_WIDTH  number of taken redirects
halted  output  1  sticky end-loop flag

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. On reset, address_imem=0, instr_count=0, redirect_count=0, halted=0, and the state is RUN. Reset takes priority over every other input, including mid-stall and in HALT.
- Decode: opcode = q_imem[31:27]; N = sign-extended q_imem[16:0]; T = q_imem[26:0] truncated to ADDR_WIDTH.
- Next-PC rules. All arithmetic is modulo 2^ADDR_WIDTH, so 4095+1 wraps to 0.
  - 00001 j: next = T.
  - 00011 jal: next = T. pc_plus1 is the value the datapath writes to $r31.
  - 00100 jr: next = rd_val[ADDR_WIDTH-1:0].
  - 00010 bne: next = PC+1+N if rd_val != rs_val, else PC+1.
  - 00110 blt: next = PC+1+N if rd_val < rs_val (signed 32-bit compare), else PC+1.
  - 10110 bex: next = T if r30_val != 0, else PC+1.
  - All other opcodes: next = PC+1.
- States:
  - RUN: if stall=1, the PC and counters hold. Otherwise PC <= next, instr_count += 1, and redirect_count += 1 if redirect.
    - If HALT_ON_SELF_LOOP=1 and next == PC on a redirect: go to HALT. In that same edge the PC loads next (unchanged) and both counters increment once.
  - HALT: the PC is frozen, counters are frozen, halted=1, redirect=0. Stall is ignored. Exit only via reset.
- Redirect vs. sequential: a taken branch with N=0 gives next = PC+1. This counts as sequential (redirect=0).
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- Stall: while stall=1, redirect=0. stall has no effect on the combinational pc_plus1.
- Latency: next PC is visible on address_imem one clock after the deciding instruction is presented. There are no delay slots.

Test Plan:
- Sequential fetch: release reset with only R-type (00000) words -> address_imem reads 0,1,2,3,4 on successive edges; redirect=0; after 5 edges instr_count=5.
- Jump: at PC=5 present q_imem=0x08000018 (j 24) -> next edge address_imem=24, redirect_count=1, redirect pulses 1 for that cycle.
- Branch: at PC=10 present bne with N=-4, rd_val=3, rs_val=7 -> PC=7. Repeat with rd_val=rs_val=7 -> PC=11 and redirect_count is unchanged.
- blt signed, jr, and wrap-around:
  - blt with rd_val=0xFFFFFFFF, rs_val=1, N=+2 at PC=20 -> PC=23.
  - jr with rd_val=0x00001FFF -> PC=0xFFF.
  - Next sequential instruction -> PC=0 (wrap).
- End loop and stall: at PC=24 present j 24 -> halted=1 after one edge and address_imem stays 24 for 100 cycles; instr_count stops incrementing. Separately, stall=1 for 3 cycles at PC=8 -> PC stays 8 and counters are held.
- Reset mid-operation: assert reset for one edge while in HALT, and again while stall=1 at PC=300 -> both cases give address_imem=0, counters=0, halted=0; fetch resumes at PC=1 on the next edge.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the program counter of the single-cycle core.
// Decodes the control-flow fields of the fetched word, picks the next PC,
// counts retired instructions and taken redirects, and latches a sticky
// halt when the program parks itself in a jump-to-self end loop.
module pc_fetch_unit #(
  parameter int ADDR_WIDTH        = 12,
  parameter int CNT_WIDTH         = 16,
  parameter int HALT_ON_SELF_LOOP = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           q_imem,
  input  logic [31:0]           rd_val,
  input  logic [31:0]           rs_val,
  input  logic [31:0]           r30_val,
  input  logic                  stall,
  output logic [ADDR_WIDTH-1:0] address_imem,
  output logic [ADDR_WIDTH-1:0] pc_plus1,
  output logic                  redirect,
  output logic [CNT_WIDTH-1:0]  instr_count,
  output logic [CNT_WIDTH-1:0]  redirect_count,
  output logic                  halted
);

  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_JAL = 5'b00011;
  localparam logic [4:0] OP_JR  = 5'b00100;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_BEX = 5'b10110;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_WIDTH-1:0]  instr_cnt_q, instr_cnt_d;
  logic [CNT_WIDTH-1:0]  redir_cnt_q, redir_cnt_d;

  logic [4:0]            opcode;
  logic [31:0]           n_ext;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] branch_pc;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  take_redirect;

  // Field bits above the address width only matter for wider PCs.
  logic unused_fields;
  assign unused_fields = ^q_imem[26:17];

  assign opcode    = q_imem[31:27];
  assign n_ext     = {{15{q_imem[16]}}, q_imem[16:0]};
  assign target    = q_imem[ADDR_WIDTH-1:0];
  assign pc_plus1  = pc_q + ADDR_WIDTH'(1);
  // Truncating the sign-extended offset gives the correct modular sum.
  assign branch_pc = pc_plus1 + n_ext[ADDR_WIDTH-1:0];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Next-PC selection from the control-flow fields of the current word.
  always_comb begin
    next_pc = pc_plus1;
    case (opcode)
      OP_J, OP_JAL: next_pc = target;
      OP_JR:        next_pc = rd_val[ADDR_WIDTH-1:0];
      OP_BNE:       if (rd_val != rs_val) next_pc = branch_pc;
      OP_BLT:       if ($signed(rd_val) < $signed(rs_val)) next_pc = branch_pc;
      OP_BEX:       if (r30_val != 32'd0) next_pc = target;
      default:      next_pc = pc_plus1;
    endcase
  end

  // RUN/HALT next-state, PC and counter updates; a branch that lands on
  // PC+1 (N=0) is treated as sequential and is not a redirect.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_cnt_d   = instr_cnt_q;
    redir_cnt_d   = redir_cnt_q;
    take_redirect = 1'b0;
    if (state_q == ST_RUN && !stall) begin
      take_redirect = (next_pc != pc_plus1);
      pc_d          = next_pc;
      instr_cnt_d   = sat_inc(instr_cnt_q);
      if (take_redirect) begin
        redir_cnt_d = sat_inc(redir_cnt_q);
      end
      if ((HALT_ON_SELF_LOOP != 0) && take_redirect && (next_pc == pc_q)) begin
        state_d = ST_HALT;
      end
    end
  end

  // State register; reset wins over stall and over HALT.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      pc_q        <= '0;
      instr_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_cnt_q <= instr_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign address_imem   = pc_q;
  assign redirect       = take_redirect;
  assign instr_count    = instr_cnt_q;
  assign redirect_count = redir_cnt_q;
  assign halted         = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a stimulus process drives directed
// and random words, a reference model predicts each cycle's outcome and
// queues it, and a monitor process compares the DUT against the queue.
// A second instance with 4-bit counters exposes saturation.
module tb_pc_fetch_unit;

  logic        clock;
  logic        reset;
  logic [31:0] q_imem, rd_val, rs_val, r30_val;
  logic        stall;
  logic [11:0] address_imem, pc_plus1;
  logic        redirect, halted;
  logic [15:0] instr_count, redirect_count;
  logic [11:0] address_imem_s, pc_plus1_s;
  logic        redirect_s, halted_s;
  logic [3:0]  instr_count_s, redirect_count_s;

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_unit #(.ADDR_WIDTH(12), .CNT_WIDTH(16), .HALT_ON_SELF_LOOP(1)) dut (
    .clock(clock), .reset(reset), .q_imem(q_imem), .rd_val(rd_val),
    .rs_val(rs_val), .r30_val(r30_val), .stall(stall),
    .address_imem(address_imem), .pc_plus1(pc_plus1), .redirect(redirect),
    .instr_count(instr_count), .redirect_count(redirect_count), .halted(halted)
  );

  pc_fetch_unit #(.ADDR_WIDTH(12), .CNT_WIDTH(4), .HALT_ON_SELF_LOOP(1)) dut_s (
    .clock(clock), .reset(reset), .q_imem(q_imem), .rd_val(rd_val),
    .rs_val(rs_val), .r30_val(r30_val), .stall(stall),
    .address_imem(address_imem_s), .pc_plus1(pc_plus1_s), .redirect(redirect_s),
    .instr_count(instr_count_s), .redirect_count(redirect_count_s), .halted(halted_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit chk_red;
    int pre_pc;
    int pre_halted;
    int exp_red;
    int exp_pp1;
    int post_pc;
    int post_ic;
    int post_rc;
    int post_halted;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state: counts are kept unbounded and clipped on compare.
  int m_pc = 0;
  int m_ic = 0;
  int m_rc = 0;
  int m_halt = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic int clip(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Next PC straight from the instruction-set rules, 12-bit modular.
  function automatic int ref_next(input int pc, input logic [31:0] q,
                                  input logic [31:0] rd, input logic [31:0] rs,
                                  input logic [31:0] r30);
    logic [4:0] op;
    int t, n, seq;
    op  = q[31:27];
    t   = {20'd0, q[11:0]};
    n   = {{15{q[16]}}, q[16:0]};
    seq = (pc + 1) & 4095;
    case (op)
      5'd1, 5'd3: return t;
      5'd4:       return {20'd0, rd[11:0]};
      5'd2:       return (rd != rs) ? ((pc + 1 + n) & 4095) : seq;
      5'd6:       return ($signed(rd) < $signed(rs)) ? ((pc + 1 + n) & 4095) : seq;
      5'd22:      return (r30 != 32'd0) ? t : seq;
      default:    return seq;
    endcase
  endfunction

  function automatic logic [31:0] enc_t(input logic [4:0] op, input int t);
    return {op, t[26:0]};
  endfunction

  function automatic logic [31:0] enc_n(input logic [4:0] op, input int n);
    return {op, 10'd0, n[16:0]};
  endfunction

  // One cycle of stimulus plus the model's prediction for it.
  task automatic step(input logic [31:0] q, input logic [31:0] rd,
                      input logic [31:0] rs, input logic [31:0] r30,
                      input logic st, input logic rst);
    exp_t e;
    int nx;
    @(posedge clock);
    #1;
    q_imem = q; rd_val = rd; rs_val = rs; r30_val = r30; stall = st; reset = rst;
    e.chk_red    = !rst;
    e.pre_pc     = m_pc;
    e.pre_halted = m_halt;
    e.exp_pp1    = (m_pc + 1) & 4095;
    e.exp_red    = 0;
    if (rst) begin
      m_pc = 0; m_ic = 0; m_rc = 0; m_halt = 0;
    end else if (m_halt == 0 && !st) begin
      nx = ref_next(m_pc, q, rd, rs, r30);
      if (nx != e.exp_pp1) begin
        e.exp_red = 1;
        m_rc++;
      end
      m_ic++;
      if (e.exp_red == 1 && nx == m_pc) m_halt = 1;
      m_pc = nx;
    end
    e.post_pc     = m_pc;
    e.post_ic     = m_ic;
    e.post_rc     = m_rc;
    e.post_halted = m_halt;
    sb_q.push_back(e);
  endtask

  // Monitor: combinational outputs mid-cycle, registered state after the edge.
  initial begin : monitor
    exp_t e;
    int txn;
    txn = 0;
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        txn++;
        chk("pc_pre", int'(address_imem), e.pre_pc);
        chk("pc_plus1", int'(pc_plus1), e.exp_pp1);
        chk("halted_pre", int'(halted), e.pre_halted);
        if (e.chk_red) chk("redirect", int'(redirect), e.exp_red);
        @(posedge clock);
        #2;
        chk("pc_post", int'(address_imem), e.post_pc);
        chk("instr_count", int'(instr_count), clip(e.post_ic, 65535));
        chk("redirect_count", int'(redirect_count), clip(e.post_rc, 65535));
        chk("halted_post", int'(halted), e.post_halted);
        chk("instr_count_sat4", int'(instr_count_s), clip(e.post_ic, 15));
        chk("redirect_count_sat4", int'(redirect_count_s), clip(e.post_rc, 15));
        $display("txn %0d pc=%0d ic=%0d rc=%0d red=%0d halt=%0d",
                 txn, address_imem, instr_count, redirect_count, e.exp_red, halted);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [31:0] rt;
    rt = 32'h0012_3456;  // opcode 00000, R-type
    reset = 1'b1; stall = 1'b0;
    q_imem = 32'd0; rd_val = 32'd0; rs_val = 32'd0; r30_val = 32'd0;

    step(rt, 0, 0, 0, 0, 1);
    step(rt, 0, 0, 0, 0, 1);
    // Sequential fetch 0..5
    repeat (5) step(rt, 0, 0, 0, 0, 0);
    // j 24 from PC 5
    step(32'h0800_0018, 0, 0, 0, 0, 0);
    // bne taken backwards and not taken
    step(enc_t(5'd1, 10), 0, 0, 0, 0, 0);
    step(enc_n(5'd2, -4), 3, 7, 0, 0, 0);
    step(enc_t(5'd1, 10), 0, 0, 0, 0, 0);
    step(enc_n(5'd2, -4), 7, 7, 0, 0, 0);
    // blt signed, jr to 0xFFF, sequential wrap
    step(enc_t(5'd1, 20), 0, 0, 0, 0, 0);
    step(enc_n(5'd6, 2), 32'hFFFF_FFFF, 1, 0, 0, 0);
    step(enc_t(5'd4, 0), 32'h0000_1FFF, 0, 0, 0, 0);
    step(rt, 0, 0, 0, 0, 0);
    // Stall for 3 cycles at PC 8 with a word that would otherwise redirect
    step(enc_t(5'd1, 8), 0, 0, 0, 0, 0);
    repeat (3) step(enc_t(5'd1, 77), 0, 0, 0, 1, 0);
    step(rt, 0, 0, 0, 0, 0);
    // jal, bex not taken / taken, taken branch with N=0 (sequential)
    step(enc_t(5'd3, 100), 0, 0, 0, 0, 0);
    step(enc_t(5'd22, 40), 0, 0, 0, 0, 0);
    step(enc_t(5'd22, 40), 0, 0, 5, 0, 0);
    step(enc_n(5'd2, 0), 1, 2, 0, 0, 0);
    // Reset while stalled at PC 300, then resume at 1
    step(enc_t(5'd1, 300), 0, 0, 0, 0, 0);
    step(rt, 0, 0, 0, 1, 1);
    step(rt, 0, 0, 0, 0, 0);
    // End loop at 24, frozen for 100 cycles, then reset out of HALT
    step(enc_t(5'd1, 24), 0, 0, 0, 0, 0);
    step(enc_t(5'd1, 24), 0, 0, 0, 0, 0);
    repeat (100) step($urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 0);
    step(rt, 0, 0, 0, 0, 1);
    step(rt, 0, 0, 0, 0, 0);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] q, rd, rs, r30;
      logic st, rst;
      int n;
      n   = $urandom_range(0, 12) - 6;
      rd  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      rs  = ($urandom_range(0, 3) == 0) ? rd : $urandom;
      r30 = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      case ($urandom_range(0, 9))
        0:       q = {5'b00000, 27'($urandom)};
        1:       q = enc_t(5'd1, int'($urandom_range(0, 4095)));
        2:       q = enc_t(5'd3, int'($urandom_range(0, 4095)));
        3:       q = enc_t(5'd4, 0);
        4:       q = {5'b00010, 10'($urandom), n[16:0]};
        5:       q = {5'b00110, 10'($urandom), n[16:0]};
        6:       q = enc_t(5'd22, int'($urandom_range(0, 4095)));
        7:       q = $urandom;
        default: q = {5'b00000, 27'($urandom)};
      endcase
      st  = ($urandom_range(0, 4) == 0);
      rst = (m_halt != 0) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 299) == 0);
      step(q, rd, rs, r30, st, rst);
    end

    repeat (3) @(posedge clock);
    #3;
    if (sb_q.size() != 0) chk("scoreboard_drain", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
